tm_alu_rollback: RTL and testbench

- Inverse of the transaction-manager running-average update: it undoes one sample when a transaction aborts.
- Given the updated average A and count N, plus the aborted transaction's length C, it recovers A_old = (A*N - C)/(N-1) and N_old = N-1.
- Sits beside the TM ALU in the transaction manager, on the abort/rollback path.
- Multi-cycle engine: valid/ready handshake on both sides, one 1-cycle multiply, an iterative 16-by-8 restoring divider, one operation in flight.

---
 rtl/tm_alu_rollback.sv | 171 +++++++++++++++++
 tb/tb_tm_alu_rollback.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_alu_rollback.sv
// tm_alu_rollback: undoes one running-average sample on transaction abort.
//   A_old = (A*N - C) / (N-1), N_old = N-1.
// Flow: IDLE -> MUL (A*N) -> SUB (clamp, load divider) -> DIV (16 cycles,
// restoring, MSB first) -> DONE (hold until consumed) -> IDLE.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1; once out_valid rises, the result and error flags stay frozen until
// that transfer; in_ready is 1 only in IDLE.
// Optional build macro TM_RB_ROUND_EN: round-half-up quotient instead of
// truncation (adds (N-1)>>1 to the dividend).
module tm_alu_rollback #(
  parameter int DIV_ITERS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] AvgTxLen,
  input  logic [7:0] InstExed,
  input  logic [7:0] CurTxLen,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] AvgTxLen_old,
  output logic [7:0] InstExed_old,
  output logic       err_underflow,
  output logic       err_neg,
  output logic       err_sat,
  output logic [2:0] dbg_state
);

  localparam int CW = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    SUB  = 3'd2,
    DIV  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state_q;
  logic [7:0]    a_q, n_q, c_q;
  logic [15:0]   p_q;
  logic [15:0]   dvd_q;      // dividend, shifted out MSB first; quotient shifts in
  logic [8:0]    rem_q;      // partial remainder
  logic [7:0]    dsr_q;      // divisor N-1
  logic [CW-1:0] cnt_q;
  logic          in_ready_q, out_valid_q;
  logic [7:0]    avg_old_q, n_old_q;
  logic          err_uf_q, err_neg_q, err_sat_q;

  // Subtract/clamp stage and divisor derived from the captured operands.
  logic [7:0]    dsr_c;
  logic [15:0]   c_ext;
  logic          neg_c;
  logic [15:0]   dvd_c;

  always_comb begin
    dsr_c = n_q - 8'd1;
    c_ext = {8'h00, c_q};
    neg_c = (p_q < c_ext);
    dvd_c = neg_c ? 16'h0000 : (p_q - c_ext);
`ifdef TM_RB_ROUND_EN
    dvd_c = dvd_c + {9'h000, dsr_c[7:1]};
`endif
  end

  // One restoring-division step: shift in next dividend bit, trial subtract.
  logic [8:0]  rem_sh, rem_nx;
  logic        q_bit;
  logic [15:0] q_nx;

  always_comb begin
    rem_sh = (rem_q << 1) | {8'h00, dvd_q[15]};
    q_bit  = (rem_sh >= {1'b0, dsr_q});
    rem_nx = q_bit ? (rem_sh - {1'b0, dsr_q}) : rem_sh;
    q_nx   = {dvd_q[14:0], q_bit};
  end

  // Control FSM with registered handshake, result and error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      n_q         <= '0;
      c_q         <= '0;
      p_q         <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      avg_old_q   <= '0;
      n_old_q     <= '0;
      err_uf_q    <= 1'b0;
      err_neg_q   <= 1'b0;
      err_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= AvgTxLen;
            n_q        <= InstExed;
            c_q        <= CurTxLen;
            err_uf_q   <= 1'b0;
            err_neg_q  <= 1'b0;
            err_sat_q  <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= MUL;
          end
        end
        MUL: begin
          p_q <= {8'h00, a_q} * {8'h00, n_q};
          if (n_q <= 8'd1) begin
            // Nothing to divide: either an empty history or the only sample.
            avg_old_q   <= '0;
            n_old_q     <= '0;
            err_uf_q    <= (n_q == 8'd0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= SUB;
          end
        end
        SUB: begin
          dvd_q     <= dvd_c;
          err_neg_q <= neg_c;
          dsr_q     <= dsr_c;
          rem_q     <= '0;
          cnt_q     <= '0;
          state_q   <= DIV;
        end
        DIV: begin
          dvd_q <= q_nx;
          rem_q <= rem_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            avg_old_q   <= (q_nx[15:8] != 8'h00) ? 8'hFF : q_nx[7:0];
            err_sat_q   <= (q_nx[15:8] != 8'h00);
            n_old_q     <= dsr_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign AvgTxLen_old  = avg_old_q;
  assign InstExed_old  = n_old_q;
  assign err_underflow = err_uf_q;
  assign err_neg       = err_neg_q;
  assign err_sat       = err_sat_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_tm_alu_rollback.sv
// Bench for tm_alu_rollback: arithmetic reference model, per-cycle compare
// process, directed vectors with hand-computed literal expectations.
module tb_tm_alu_rollback;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] AvgTxLen = '0, InstExed = '0, CurTxLen = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] AvgTxLen_old, InstExed_old;
  logic       err_underflow, err_neg, err_sat;
  logic [2:0] dbg_state;

  tm_alu_rollback #(.DIV_ITERS(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .AvgTxLen(AvgTxLen), .InstExed(InstExed), .CurTxLen(CurTxLen),
    .out_valid(out_valid), .out_ready(out_ready),
    .AvgTxLen_old(AvgTxLen_old), .InstExed_old(InstExed_old),
    .err_underflow(err_underflow), .err_neg(err_neg), .err_sat(err_sat),
    .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] avg;
    logic [7:0] n_old;
    logic       eu, en, es;
    logic [4:0] lat;
  } exp_t;

  function automatic exp_t model(input int a, input int n, input int c);
    exp_t e;
    int p, d, q;
    e = '0;
    if (n == 0) begin
      e.eu = 1'b1;
      e.lat = 5'd2;
    end else if (n == 1) begin
      e.lat = 5'd2;
    end else begin
      p = a * n;
      if (p < c) begin
        d = 0;
        e.en = 1'b1;
      end else begin
        d = p - c;
      end
`ifdef TM_RB_ROUND_EN
      d = d + (n - 1) / 2;
`endif
      q = d / (n - 1);
      if (q > 255) begin
        e.es = 1'b1;
        e.avg = 8'd255;
      end else begin
        e.avg = q[7:0];
      end
      e.n_old = 8'(n - 1);
      e.lat = 5'd19;
    end
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   acc_cyc = 0;
  logic [7:0] got_avg, got_n;
  logic [2:0] got_err;
  int   got_lat;
  bit   seen_valid = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Every cycle out of reset: handshake signals against the model timeline,
  // and result fields against the head expectation while valid.
  always @(negedge clk) begin
    exp_t cur;
    bit   busy, ev;
    if (!reset) begin
      busy = (exp_q.size() != 0);
      cur  = busy ? exp_q[0] : '0;
      ev   = busy && ((cyc - acc_cyc) >= int'(cur.lat));
      chk("in_ready", {15'd0, in_ready}, {15'd0, !busy});
      chk("out_valid", {15'd0, out_valid}, {15'd0, ev});
      if (ev && out_valid) begin
        if (!seen_valid) begin
          got_lat = cyc - acc_cyc;
          seen_valid = 1'b1;
        end
        chk("avg_old", {8'd0, AvgTxLen_old}, {8'd0, cur.avg});
        chk("n_old", {8'd0, InstExed_old}, {8'd0, cur.n_old});
        chk("errs", {13'd0, err_underflow, err_neg, err_sat}, {13'd0, cur.eu, cur.en, cur.es});
        if (out_ready) begin
          got_avg = AvgTxLen_old;
          got_n   = InstExed_old;
          got_err = {err_underflow, err_neg, err_sat};
          seen_valid = 1'b0;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] n, input logic [7:0] c);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("accept_wait", {15'd0, in_ready}, 16'd1);
    AvgTxLen = a;
    InstExed = n;
    CurTxLen = c;
    in_valid = 1'b1;
    acc_cyc  = cyc;
    @(posedge clk); #1;
    exp_q.push_back(model(a, n, c));
    in_valid = 1'b0;
    // Inputs after acceptance must be ignored.
    AvgTxLen = 8'($urandom_range(0, 255));
    InstExed = 8'($urandom_range(0, 255));
    CurTxLen = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_wait", {15'd0, exp_q.size() == 0}, 16'd1);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] n, input logic [7:0] c);
    send(a, n, c);
    wait_done();
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_state"}, {13'd0, dbg_state}, 16'd0);
    chk({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
    chk({tag, "_out_valid"}, {15'd0, out_valid}, 16'd0);
    chk({tag, "_outs"}, {AvgTxLen_old, InstExed_old}, 16'd0);
    chk({tag, "_errs"}, {13'd0, err_underflow, err_neg, err_sat}, 16'd0);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    exp_t m;
    int k;

    // Model pins (hand-computed).
    m = model(10, 4, 16);
    chk("model_10_4_16", {m.avg, m.n_old}, {8'd8, 8'd3});
    m = model(255, 255, 0);
    chk("model_sat", {m.avg, 5'd0, m.eu, m.en, m.es}, {8'd255, 8'd1});
    m = model(10, 3, 5);
`ifdef TM_RB_ROUND_EN
    chk("model_round", {8'd0, m.avg}, 16'd13);
`else
    chk("model_trunc", {8'd0, m.avg}, 16'd12);
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle_zero("reset");

    // Basic normal path.
    run(8'd10, 8'd4, 8'd16);
    chk("t1_lat", 16'(got_lat), 16'd19);
    chk("t1_res", {got_avg, got_n}, {8'd8, 8'd3});
    chk("t1_err", {13'd0, got_err}, 16'd0);

    // Short paths.
    run(8'd50, 8'd1, 8'd50);
    chk("n1_lat", 16'(got_lat), 16'd2);
    chk("n1_res", {got_avg, got_n, 5'd0, got_err}, 24'd0);
    run(8'd7, 8'd0, 8'd3);
    chk("n0_lat", 16'(got_lat), 16'd2);
    chk("n0_res", {got_avg, got_n, 5'd0, got_err}, {16'd0, 8'b100});

    // Clamp and saturate.
    run(8'd2, 8'd3, 8'd20);
    chk("neg_res", {got_avg, got_n, 5'd0, got_err}, {8'd0, 8'd2, 8'b010});
    run(8'd255, 8'd255, 8'd0);
    chk("sat_res", {got_avg, got_n, 5'd0, got_err}, {8'd255, 8'd254, 8'b001});

    // Rounding-sensitive vector.
    run(8'd10, 8'd3, 8'd5);
`ifdef TM_RB_ROUND_EN
    chk("round_res", {8'd0, got_avg}, 16'd13);
`else
    chk("trunc_res", {8'd0, got_avg}, 16'd12);
`endif

    // Extra patterns handled by the model.
    run(8'd100, 8'd2, 8'd50);
    chk("div1_res", {got_avg, got_n}, {8'd150, 8'd1});
    run(8'd255, 8'd200, 8'd0);
    run(8'd0, 8'd2, 8'd0);
    run(8'd33, 8'd7, 8'd255);
    run(8'd1, 8'd255, 8'd255);

    // Backpressure: hold out_ready low in DONE, stray in_valid ignored.
    out_ready = 1'b0;
    send(8'd10, 8'd4, 8'd16);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_valid_wait", {15'd0, out_valid}, 16'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1);
      AvgTxLen = 8'd99;
      InstExed = 8'd9;
      CurTxLen = 8'd1;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done();
    chk("bp_res", {got_avg, got_n}, {8'd8, 8'd3});
    @(negedge clk);
    chk("bp_ready_after", {15'd0, in_ready}, 16'd1);

    // Reset mid-division, then a normal request.
    send(8'd10, 8'd4, 8'd16);
    k = 0;
    while ((cyc - acc_cyc) < 8 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_dbg_div", {13'd0, dbg_state}, 16'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    seen_valid = 1'b0;
    @(negedge clk);
    chk_idle_zero("midrst");
    run(8'd10, 8'd4, 8'd16);
    chk("post_rst_res", {got_avg, got_n}, {8'd8, 8'd3});

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
